// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the DataMemory port arbiter: port identifiers and
// default bus widths used by the interface, the arbiter and its sub-module.
package dmem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Requester identity; also used as the response tag and the priority pointer
  typedef enum logic {
    PORT_IFETCH = 1'b0,
    PORT_LSU    = 1'b1
  } port_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the two requester ports plus the DataMemory command/response
// wires. The arbiter uses the slave view; the requesters and the memory
// side (collectively) use the master view.
interface dmem_port_arbiter_if
  import dmem_port_arbiter_pkg::*;
#(
  parameter int addresswidth = DEF_ADDR_W,
  parameter int width        = DEF_DATA_W
);

  logic                    r0_req;
  logic                    r0_we;
  logic [addresswidth-1:0] r0_addr;
  logic [width-1:0]        r0_wdata;
  logic                    r0_gnt;
  logic                    r0_rvalid;
  logic [width-1:0]        r0_rdata;

  logic                    r1_req;
  logic                    r1_we;
  logic [addresswidth-1:0] r1_addr;
  logic [width-1:0]        r1_wdata;
  logic                    r1_gnt;
  logic                    r1_rvalid;
  logic [width-1:0]        r1_rdata;

  logic [addresswidth-1:0] mem_address;
  logic                    mem_writeEnable;
  logic [width-1:0]        mem_dataIn;
  logic [width-1:0]        mem_dataOut;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_address, mem_writeEnable, mem_dataIn,
    input  mem_dataOut
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_address, mem_writeEnable, mem_dataIn,
    output mem_dataOut
  );

endinterface

// File: rtl/DataMemory.sv
// Single-port synchronous-read data memory, write-first: a write returns the
// written word on dataOut the following cycle. No reset on the array.
module DataMemory #(
  parameter int addresswidth = 32,
  parameter int width        = 32,
  parameter int depth        = 1024
) (
  input  logic                    clk,
  input  logic [addresswidth-1:0] address,
  input  logic                    writeEnable,
  input  logic [width-1:0]        dataIn,
  output logic [width-1:0]        dataOut
);

  localparam int IW = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [IW-1:0]    index;
  logic             unused_address_hi;

  assign index             = address[IW-1:0];
  assign unused_address_hi = ^address[addresswidth-1:IW];

  // Write the array and present either the new word or the stored word next cycle
  always_ff @(posedge clk) begin
    if (writeEnable) begin
      mem[index] <= dataIn;
      dataOut    <= dataIn;
    end else begin
      dataOut    <= mem[index];
    end
  end

endmodule

// File: rtl/dmem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. A lone request always wins; on a tie the
// port named by prio_ptr wins, and the pointer then moves to the other port
// so continuous contention alternates strictly.
module rr_arbiter2
  import dmem_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_e prio_ptr;

  // Same-cycle grant decision from the request vector and the tie pointer
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (prio_ptr == PORT_LSU) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Hand tie priority to the port that was not just served; hold when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_ptr <= PORT_IFETCH;
    end else if (gnt[0]) begin
      prio_ptr <= PORT_LSU;
    end else if (gnt[1]) begin
      prio_ptr <= PORT_IFETCH;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one DataMemory between instruction fetch (port 0) and load/store
// (port 1). The winning port drives the memory command combinationally and
// a one-stage tag/valid register steers the returning data back to it.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int addresswidth = DEF_ADDR_W,
  parameter int width        = DEF_DATA_W
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
);

  logic [1:0]              req;
  logic [1:0]              gnt;
  port_e                   grant_port;
  logic                    resp_valid;
  port_e                   resp_tag;
  logic [addresswidth-1:0] cmd_addr;
  logic                    cmd_we;
  logic [width-1:0]        cmd_wdata;

  assign req = {bus.r1_req, bus.r0_req};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign bus.r0_gnt = gnt[0];
  assign bus.r1_gnt = gnt[1];
  assign grant_port = gnt[1] ? PORT_LSU : PORT_IFETCH;

  // Forward the winner's command to memory; an idle cycle issues a zeroed read
  always_comb begin
    cmd_addr  = '0;
    cmd_we    = 1'b0;
    cmd_wdata = '0;
    if (gnt[0]) begin
      cmd_addr  = bus.r0_addr;
      cmd_we    = bus.r0_we;
      cmd_wdata = bus.r0_wdata;
    end else if (gnt[1]) begin
      cmd_addr  = bus.r1_addr;
      cmd_we    = bus.r1_we;
      cmd_wdata = bus.r1_wdata;
    end
  end

  assign bus.mem_address     = cmd_addr;
  assign bus.mem_writeEnable = cmd_we;
  assign bus.mem_dataIn      = cmd_wdata;

  // Remember who owns the memory output next cycle; reset drops it in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_tag   <= PORT_IFETCH;
    end else begin
      resp_valid <= |gnt;
      resp_tag   <= grant_port;
    end
  end

  assign bus.r0_rvalid = resp_valid && (resp_tag == PORT_IFETCH);
  assign bus.r1_rvalid = resp_valid && (resp_tag == PORT_LSU);
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_dataOut : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_dataOut : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for the DataMemory port arbiter: directed scenarios followed by a
// randomized two-port mix, all checked against a transaction-level model.
module tb_dmem_port_arbiter;

  logic clk;
  logic reset;

  int compareCount;
  int failCount;

  // Reference model state
  logic [31:0] modelMem  [0:1023];
  bit          modelKnown[0:1023];
  int          favour;
  bit          pendValid;
  int          pendTag;
  logic [31:0] pendData;
  bit          pendKnown;

  logic [1:0]  obsGnt;
  logic        obsRv0;
  logic [31:0] obsRd0;

  dmem_port_arbiter_if #(.addresswidth(32), .width(32)) bus ();

  dmem_port_arbiter #(.addresswidth(32), .width(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  DataMemory #(.addresswidth(32), .width(32), .depth(1024)) u_mem (
    .clk         (clk),
    .address     (bus.mem_address),
    .writeEnable (bus.mem_writeEnable),
    .dataIn      (bus.mem_dataIn),
    .dataOut     (bus.mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    favour    = 0;
    pendValid = 0;
    pendTag   = 0;
    pendData  = '0;
    pendKnown = 0;
  endtask

  // One clock of stimulus: drive both ports, check the cycle, advance the model
  task automatic applyStimulus(
    input  logic q0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
    input  logic q1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
    output logic [1:0] gOut, output logic rv0Out, output logic [31:0] rd0Out
  );
    logic [1:0]  expGnt;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic        expWe;
    int          win;
    int          idx;
    @(negedge clk);
    bus.r0_req = q0; bus.r0_we = we0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1; bus.r1_we = we1; bus.r1_addr = a1; bus.r1_wdata = d1;
    #1;
    if (q0 && q1) expGnt = (favour == 0) ? 2'b01 : 2'b10;
    else          expGnt = {q1, q0};
    checkOutput("gnt", 64'({bus.r1_gnt, bus.r0_gnt}), 64'(expGnt));

    checkOutput("rvalid0", 64'(bus.r0_rvalid), 64'(pendValid && pendTag == 0));
    checkOutput("rvalid1", 64'(bus.r1_rvalid), 64'(pendValid && pendTag == 1));
    if (pendValid && pendTag == 0) begin
      if (pendKnown) checkOutput("rdata0", 64'(bus.r0_rdata), 64'(pendData));
      checkOutput("rdata1Idle", 64'(bus.r1_rdata), 64'd0);
    end else if (pendValid && pendTag == 1) begin
      if (pendKnown) checkOutput("rdata1", 64'(bus.r1_rdata), 64'(pendData));
      checkOutput("rdata0Idle", 64'(bus.r0_rdata), 64'd0);
    end else begin
      checkOutput("rdata0Idle", 64'(bus.r0_rdata), 64'd0);
      checkOutput("rdata1Idle", 64'(bus.r1_rdata), 64'd0);
    end

    win = -1;
    expAddr = '0; expWe = 1'b0; expData = '0;
    if (expGnt == 2'b01) begin
      win = 0; expAddr = a0; expWe = we0; expData = d0;
    end else if (expGnt == 2'b10) begin
      win = 1; expAddr = a1; expWe = we1; expData = d1;
    end
    checkOutput("memAddr", 64'(bus.mem_address), 64'(expAddr));
    checkOutput("memWe", 64'(bus.mem_writeEnable), 64'(expWe));
    checkOutput("memDataIn", 64'(bus.mem_dataIn), 64'(expData));

    gOut   = {bus.r1_gnt, bus.r0_gnt};
    rv0Out = bus.r0_rvalid;
    rd0Out = bus.r0_rdata;

    pendValid = (win >= 0);
    if (win >= 0) begin
      idx     = int'(expAddr[9:0]);
      pendTag = win;
      if (expWe) begin
        modelMem[idx]   = expData;
        modelKnown[idx] = 1;
        pendData        = expData;
        pendKnown       = 1;
      end else begin
        pendData  = modelMem[idx];
        pendKnown = modelKnown[idx];
      end
      favour = 1 - win;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, obsGnt, obsRv0, obsRd0);
  endtask

  initial begin
    logic [1:0] altExp [6];
    logic       hq [2];
    logic       hwe [2];
    logic [31:0] ha [2];
    logic [31:0] hd [2];

    compareCount = 0;
    failCount    = 0;
    for (int i = 0; i < 1024; i++) begin
      modelMem[i]   = '0;
      modelKnown[i] = 0;
    end
    modelReset();

    reset = 1'b1;
    bus.r0_req = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_req = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstRvalid0", 64'(bus.r0_rvalid), 64'd0);
    checkOutput("rstRvalid1", 64'(bus.r1_rvalid), 64'd0);
    checkOutput("rstRdata0", 64'(bus.r0_rdata), 64'd0);
    checkOutput("rstMemWe", 64'(bus.mem_writeEnable), 64'd0);
    reset = 1'b0;

    // Both ports contending continuously alternate starting with port 0
    altExp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, 32'd0, 32'd0, 1, 0, 32'd1, 32'd0, obsGnt, obsRv0, obsRd0);
      checkOutput($sformatf("alt%0d", i), 64'(obsGnt), 64'(altExp[i]));
    end
    idle(1);

    // Port 1 alone gets every cycle; it also seeds the low addresses
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'(i), $urandom, obsGnt, obsRv0, obsRd0);
      checkOutput("lsuOnly", 64'(obsGnt), 64'd2);
    end

    // Read-after-write across ports
    applyStimulus(0, 0, 32'd0, 32'd0, 1, 1, 32'd5, 32'hDEADBEEF, obsGnt, obsRv0, obsRd0);
    applyStimulus(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0, obsGnt, obsRv0, obsRd0);
    applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, obsGnt, obsRv0, obsRd0);
    checkOutput("rawValid", 64'(obsRv0), 64'd1);
    checkOutput("rawData", 64'(obsRd0), 64'hDEADBEEF);

    // Idle cycles must not move priority: port 0 was served last, so port 1 wins
    idle(4);
    applyStimulus(1, 0, 32'd2, 32'd0, 1, 0, 32'd3, 32'd0, obsGnt, obsRv0, obsRd0);
    checkOutput("prioHold", 64'(obsGnt), 64'd2);
    idle(1);

    // Reset while a port 0 read response is being presented
    applyStimulus(1, 0, 32'd7, 32'd0, 0, 0, 32'd0, 32'd0, obsGnt, obsRv0, obsRd0);
    @(negedge clk);
    bus.r0_req = 0;
    bus.r1_req = 0;
    #1;
    checkOutput("inFlight", 64'(bus.r0_rvalid), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstDrop", 64'(bus.r0_rvalid), 64'd0);
    checkOutput("rstDropData", 64'(bus.r0_rdata), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    idle(3);

    // Randomized mix; requesters hold their access until granted or abandoned
    for (int p = 0; p < 2; p++) begin
      hq[p] = 0; hwe[p] = 0; ha[p] = '0; hd[p] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hq[p]) begin
          hq[p] = ($urandom_range(0, 99) < 60);
          if (hq[p]) begin
            hwe[p] = ($urandom_range(0, 99) < 40);
            ha[p]  = 32'($urandom_range(0, 15));
            hd[p]  = $urandom;
          end
        end else if ($urandom_range(0, 99) < 5) begin
          hq[p] = 0;
        end
      end
      applyStimulus(hq[0], hwe[0], ha[0], hd[0], hq[1], hwe[1], ha[1], hd[1], obsGnt, obsRv0, obsRd0);
      if (obsGnt[0]) hq[0] = 0;
      if (obsGnt[1]) hq[1] = 0;
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
